fetch_sequencer: RTL and testbench

- Instruction fetch and next-PC sequencer. It sits upstream of the opcode decoder/control unit.
- Drives the 6-bit opcode and full instruction word into decode.
- Consumes the decoder's registered branch/jump outputs plus the ALU zero flag to pick the next PC.
- Talks to instruction memory over a req/ack handshake. Multicycle: one instruction in flight at a time.

---
 rtl/fetch_sequencer_if.sv | 12 +
 rtl/fetch_sequencer.sv | 87 ++++++++
 tb/tb_fetch_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, output imem_addr, input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle fetch / next-PC sequencer: REQ -> ISSUE -> RESOLVE, one instruction in flight.
module fetch_sequencer #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   imem,
    input  logic                stall,
    input  logic                branch,
    input  logic                jump,
    input  logic                alu_zero,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4
);

    typedef enum logic [1:0] {S_REQ, S_ISSUE, S_RESOLVE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W-1:0]   br_off;
    logic [31:0]         instr_q;
    logic                req_q;
    logic                valid_q;

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign br_off   = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump target keeps the upper bits of pc+4 above the 28-bit region; needs ADDR_W > 28.
    always_comb begin
        pc_d = pc_plus4;
        if (jump)
            pc_d = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
        else if (branch && alu_zero)
            pc_d = pc_plus4 + br_off;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        state_q <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    pc_q    <= pc_d;
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                default: begin
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // Gated by reset so a request in flight drops in the very cycle reset is asserted.
    assign imem.imem_req  = req_q & ~reset;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign instr_valid    = valid_q & ~reset;
    assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a PC-level reference model.
module tb_fetch_sequencer;

    logic clk;
    logic reset;
    logic stall, branch, jump, alu_zero;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc, pc_plus4;

    logic [31:0] w_instr;
    logic [5:0]  w_opcode;
    logic        w_valid;
    logic [31:0] w_pc, w_pc4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_pc;

    fetch_sequencer_if #(.ADDR_W(32)) bus ();
    fetch_sequencer_if #(.ADDR_W(32)) bus_w ();

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem(bus),
        .stall(stall), .branch(branch), .jump(jump), .alu_zero(alu_zero),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4)
    );

    // Second instance for the wrap-around case: zero-wait memory, plain R-type.
    assign bus_w.imem_ack   = 1'b1;
    assign bus_w.imem_rdata = 32'h0000_0020;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .imem(bus_w),
        .stall(1'b0), .branch(1'b0), .jump(1'b0), .alu_zero(1'b0),
        .instr(w_instr), .opcode(w_opcode), .instr_valid(w_valid),
        .pc(w_pc), .pc_plus4(w_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [31:0] word,
                                            input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          off;
        p4  = cur + 32'd4;
        off = int'($signed(word[15:0]));
        if (j)           return {p4[31:28], word[25:0], 2'b00};
        else if (b && z) return p4 + 32'(off * 4);
        else             return p4;
    endfunction

    // Entered at a negedge inside a REQ cycle; leaves at the negedge of the following REQ cycle.
    task automatic do_instr(input logic [31:0] word, input int dly, input int nstall,
                            input logic j, input logic b, input logic z);
        for (int i = 0; i <= dly; i++) begin
            chk("req_hi", 32'(bus.imem_req), 32'd1);
            chk("req_addr", bus.imem_addr, exp_pc);
            chk("vld_in_req", 32'(instr_valid), 32'd0);
            bus.imem_ack   = (i == dly);
            bus.imem_rdata = (i == dly) ? word : $urandom;
            stall = 1'($urandom); branch = 1'($urandom); jump = 1'($urandom); alu_zero = 1'($urandom);
            @(negedge clk);
        end
        for (int s = 0; s <= nstall; s++) begin
            chk("vld_issue", 32'(instr_valid), 32'd1);
            chk("instr", instr, word);
            chk("opcode", 32'(opcode), 32'(word[31:26]));
            chk("pc", pc, exp_pc);
            chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("req_issue", 32'(bus.imem_req), 32'd0);
            stall = (s < nstall);
            bus.imem_ack = 1'($urandom); bus.imem_rdata = $urandom;
            branch = 1'($urandom); jump = 1'($urandom); alu_zero = 1'($urandom);
            @(negedge clk);
        end
        chk("vld_resolve", 32'(instr_valid), 32'd0);
        chk("req_resolve", 32'(bus.imem_req), 32'd0);
        stall = 1'($urandom); bus.imem_ack = 1'($urandom); bus.imem_rdata = $urandom;
        jump = j; branch = b; alu_zero = z;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        exp_pc = next_pc(exp_pc, word, j, b, z);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        exp_pc = 32'h0;

        // Reset held two cycles; an ack during reset must be ignored.
        @(posedge clk); #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_vld", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        @(negedge clk);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("rst_instr2", instr, 32'h0);
        chk("rst_vld2", 32'(instr_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0; bus.imem_ack = 1'b0;
        #1;

        do_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);   // addi, zero-wait -> 0x4
        do_instr(32'h0000_0020, 3, 2, 1'b0, 1'b0, 1'b0);   // wait states + stall -> 0x8
        do_instr(32'h0000_0020, 1, 0, 1'b0, 1'b1, 1'b0);   // -> 0xC
        do_instr(32'h0000_0020, 0, 1, 1'b0, 1'b0, 1'b1);   // -> 0x10
        do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1);   // taken branch -> 0xC
        chk("taken_target", exp_pc, 32'h0000_000C);
        do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);   // -> 0x10
        do_instr(32'h1000_FFFE, 2, 0, 1'b0, 1'b1, 1'b0);   // untaken -> 0x14
        do_instr(32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0);   // jump -> 0x40
        do_instr(32'h0800_0100, 1, 1, 1'b1, 1'b1, 1'b1);   // jump beats branch -> 0x400
        chk("jump_target", exp_pc, 32'h0000_0400);

        // Reset mid-request with the stale ack arriving in the reset cycle.
        for (int i = 0; i < 2; i++) begin
            chk("midrst_req", 32'(bus.imem_req), 32'd1);
            chk("midrst_addr", bus.imem_addr, 32'h0000_0400);
            bus.imem_ack = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("midrst_req_drop", 32'(bus.imem_req), 32'd0);
        @(posedge clk); #1;
        chk("midrst_vld", 32'(instr_valid), 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        @(negedge clk);
        reset = 1'b0; bus.imem_ack = 1'b0;
        #1;
        exp_pc = 32'h0;
        do_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            logic        j, b, z;
            w = $urandom;
            j = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 2) == 0);
            z = 1'($urandom);
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), j, b, z);
        end

        // Wrap-around from RESET_PC = 0xFFFF_FFFC on the second instance.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("wrap_req0", 32'(bus_w.imem_req), 32'd1);
        chk("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'h0000_0000);
        @(negedge clk);
        chk("wrap_vld", 32'(w_valid), 32'd1);
        chk("wrap_opcode", 32'(w_opcode), 32'd0);
        @(negedge clk);
        chk("wrap_resolve_req", 32'(bus_w.imem_req), 32'd0);
        @(negedge clk);
        chk("wrap_req1", 32'(bus_w.imem_req), 32'd1);
        chk("wrap_addr1", bus_w.imem_addr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
